digit_serial_adder: RTL

//  Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock,

---
 rtl/digit_serial_adder_pkg.sv | 20 ++
 rtl/digit_serial_adder_if.sv | 28 ++
 rtl/digit_serial_adder_fa_digit.sv | 31 +++
 rtl/digit_serial_adder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM state encoding and a
// constant clog2 used to size the digit counter.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder. The producer and
// consumer side (master) drives operands and out_ready; the adder (slave) answers.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co, ovf
    );

endinterface

// File: rtl/digit_serial_adder_fa_digit.sv
// Combinational DIGIT-bit ripple of full-adder cells. msb_cin is the carry into
// the top cell, needed by the caller to derive signed overflow.
module fa_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             msb_cin
);

    logic carry;

    // A loop-carried variable keeps the ripple free of a self-referencing vector.
    always_comb begin
        s       = '0;
        carry   = ci;
        msb_cin = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                msb_cin = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: a + b + ci computed DIGIT bits per clock through fa_digit,
// with carry-out, signed overflow and valid/ready flow control on both sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    digit_serial_adder_if.slave bus
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_DIGITS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_co;
    logic                   dig_msb_cin;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_shifted;

    fa_digit #(.DIGIT(DIGIT)) u_fa_digit (
        .a       (a_sh_q[DIGIT-1:0]),
        .b       (b_sh_q[DIGIT-1:0]),
        .ci      (carry_q),
        .s       (dig_s),
        .co      (dig_co),
        .msb_cin (dig_msb_cin)
    );

    // Digits enter from the MSB end so the sum is aligned after the last digit;
    // the concatenation keeps the slice legal when DIGIT equals WIDTH.
    assign sum_cat     = {dig_s, sum_q};
    assign sum_shifted = sum_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        count_d = count_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.ci;
                    count_d = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                sum_d   = sum_shifted;
                carry_d = dig_co;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_COUNT) begin
                    s_d     = sum_shifted;
                    co_d    = dig_co;
                    ovf_d   = dig_msb_cin ^ dig_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;

endmodule
